// File: rtl/lr35902_irq.sv
// LR35902 interrupt controller: IF/IE registers, fixed-priority request and vectored ack handshake.
// Optional build macro LR35902_IRQ_EDGE_EN: irq_src sampled as levels, captured on 0->1 only.
module lr35902_irq (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] dout,
  input  logic [7:0] din,
  input  logic       adr,
  input  logic       read,
  input  logic       write,
  input  logic [4:0] irq_src,
  output logic       cpu_irq,
  input  logic       cpu_ack,
  output logic [7:0] vector
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [4:0]  r_if;
  logic [7:0]  r_ie;
  logic [7:0]  r_vec;
  logic        r_pread;
  logic        r_pwrite;
  logic        r_pack;

  logic        w_rd_rise;
  logic        w_wr_commit;
  logic        w_ack_rise;
  logic [4:0]  w_pend;
  logic [4:0]  w_sel_mask;
  logic [2:0]  w_sel;
  logic [7:0]  w_live_vec;
  logic [4:0]  w_clr;
  logic        w_vec_load;
  logic [4:0]  w_src_set;
  logic [4:0]  w_if_base;
  logic [4:0]  w_if_next;

  assign w_rd_rise   = read & ~r_pread;
  assign w_wr_commit = r_pwrite & ~write;
  assign w_ack_rise  = cpu_ack & ~r_pack;

  assign w_pend  = r_if & r_ie[4:0];
  assign cpu_irq = |w_pend;

  // Lowest set bit wins; the isolated one-hot mask drives the clear.
  assign w_sel_mask = w_pend & (~w_pend + 5'd1);

  always_comb begin
    w_sel = 3'd0;
    casez (w_pend)
      5'b????1: w_sel = 3'd0;
      5'b???10: w_sel = 3'd1;
      5'b??100: w_sel = 3'd2;
      5'b?1000: w_sel = 3'd3;
      5'b10000: w_sel = 3'd4;
      default:  w_sel = 3'd0;
    endcase
  end

  assign w_live_vec = cpu_irq ? (8'h40 + {2'b00, w_sel, 3'b000}) : 8'h00;

`ifdef LR35902_IRQ_EDGE_EN
  logic [4:0] r_src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src <= '0;
    end else begin
      r_src <= irq_src;
    end
  end

  assign w_src_set = irq_src & ~r_src;
`else
  assign w_src_set = irq_src;
`endif

  always_comb begin
    w_state_next = r_state;
    w_clr        = '0;
    w_vec_load   = 1'b0;
    vector       = 8'h00;
    case (r_state)
      IDLE: begin
        vector = w_live_vec;
        if (w_ack_rise) begin
          w_clr        = w_sel_mask;
          w_vec_load   = 1'b1;
          w_state_next = GRANT;
        end
      end
      GRANT: begin
        vector = r_vec;
        if (!cpu_ack) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Bus write first, then ack clear, then source set, so a new request is never lost.
  assign w_if_base = (w_wr_commit && !adr) ? din[4:0] : r_if;
  assign w_if_next = (w_if_base & ~w_clr) | w_src_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if     <= '0;
      r_ie     <= '0;
      r_vec    <= '0;
      r_pread  <= 1'b0;
      r_pwrite <= 1'b0;
      r_pack   <= 1'b0;
      dout     <= '0;
    end else begin
      r_pread  <= read;
      r_pwrite <= write;
      r_pack   <= cpu_ack;
      r_if     <= w_if_next;
      if (w_wr_commit && adr) begin
        r_ie <= din;
      end
      if (w_vec_load) begin
        r_vec <= w_live_vec;
      end
      if (w_rd_rise) begin
        dout <= adr ? r_ie : {3'b111, r_if};
      end
    end
  end

endmodule
